// File: rtl/orao_tap_pkg.sv
// rtl/orao_tap_pkg.sv - shared TAP constants and recorder state type for the Orao tape path
package orao_tap_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        RECORD,
        DRAIN,
        DONE
    } tap_rec_state_t;

    localparam logic [7:0] TAP_HI        = 8'h40;
    localparam logic [7:0] TAP_LO        = 8'h00;
    localparam int         TAP_LEVEL_BIT = 6;

    function automatic logic [7:0] tap_byte(input logic level);
        return level ? TAP_HI : TAP_LO;
    endfunction

endpackage

// File: rtl/orao_tap_fifo.sv
// rtl/orao_tap_fifo.sv - synchronous first-word-fall-through FIFO with registered full/empty flags
module orao_tap_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic [AW:0]      count_next;
    logic             do_pop;
    logic             do_push;

    // A write into a full FIFO is allowed when the head leaves in the same cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        count_next = count;
        if (do_push && !do_pop)
            count_next = count + 1'b1;
        else if (!do_push && do_pop)
            count_next = count - 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count_next;
            full  <= (count_next == (AW+1)'(DEPTH));
            empty <= (count_next == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= wr_data;
    end

    assign rd_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/orao_tap_recorder.sv
// rtl/orao_tap_recorder.sv - cassette line sampler producing a TAP byte stream; ORAO_TAPREC_AUTOSTOP_EN enables silence auto-stop
module orao_tap_recorder
    import orao_tap_pkg::*;
#(
    parameter int          SAMPLE_DIV   = 44,
    parameter int          FIFO_DEPTH   = 16,
    parameter logic [15:0] IDLE_SAMPLES = 16'd8192
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        ce_1m,
    input  logic        arm,
    input  logic        tape_in,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        recording,
    output logic        done,
    output logic        overflow,
    output logic [23:0] byte_count
);

    tap_rec_state_t state;
    logic           sync1;
    logic           lvl;
    logic           lvl_q;
    logic           arm_q;
    logic [7:0]     div;
    logic           lvl_edge;
    logic           arm_rise;
    logic           tick;
    logic           start;
    logic           push;
    logic           pop;
    logic           accept;
    logic           stop_silent;
    logic           fifo_full;
    logic           fifo_empty;

    assign lvl_edge = lvl ^ lvl_q;
    assign arm_rise = arm && !arm_q;
    assign tick     = (state == RECORD) && ce_1m && (div == 8'(SAMPLE_DIV - 1));
    assign start    = (state == ARMED) && arm && lvl_edge;
    assign push     = start || tick;
    assign pop      = out_valid && out_ready;
    assign accept   = push && (!fifo_full || pop);

`ifdef ORAO_TAPREC_AUTOSTOP_EN
    logic [15:0] silence;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n)
            silence <= '0;
        else if (lvl_edge)
            silence <= '0;
        else if (tick)
            silence <= silence + 16'd1;
    end

    // An edge coinciding with a tick restarts the silence window instead of extending it.
    assign stop_silent = tick && !lvl_edge && (silence + 16'd1 == IDLE_SAMPLES);
`else
    logic unused_idle;
    assign unused_idle = ^IDLE_SAMPLES;
    assign stop_silent = 1'b0;
`endif

    // arm_q resets high so an arm level held through reset is not mistaken for a new request.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= 1'b0;
            lvl   <= 1'b0;
            lvl_q <= 1'b0;
            arm_q <= 1'b1;
        end else begin
            sync1 <= tape_in;
            lvl   <= sync1;
            lvl_q <= lvl;
            arm_q <= arm;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            recording  <= 1'b0;
            done       <= 1'b0;
            overflow   <= 1'b0;
            byte_count <= '0;
            div        <= '0;
        end else begin
            if (accept && byte_count != 24'hFFFFFF)
                byte_count <= byte_count + 24'd1;
            if (push && !accept)
                overflow <= 1'b1;

            case (state)
                IDLE: begin
                    if (arm_rise) begin
                        state      <= ARMED;
                        overflow   <= 1'b0;
                        byte_count <= '0;
                    end
                end
                ARMED: begin
                    if (!arm) begin
                        state <= IDLE;
                    end else if (lvl_edge) begin
                        state      <= RECORD;
                        recording  <= 1'b1;
                        div        <= '0;
                        byte_count <= {23'd0, accept};
                    end
                end
                RECORD: begin
                    if (ce_1m)
                        div <= (div == 8'(SAMPLE_DIV - 1)) ? 8'd0 : div + 8'd1;
                    if (!arm || stop_silent) begin
                        state     <= DRAIN;
                        recording <= 1'b0;
                        div       <= '0;
                    end
                end
                DRAIN: begin
                    if (fifo_empty) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    if (arm_rise) begin
                        state      <= ARMED;
                        done       <= 1'b0;
                        overflow   <= 1'b0;
                        byte_count <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    orao_tap_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk     (clk_sys),
        .rst_n   (reset_n),
        .push    (push),
        .wr_data (tap_byte(lvl)),
        .pop     (pop),
        .rd_data (out_data),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign out_valid = !fifo_empty;

endmodule

// File: tb/tb_orao_tap_recorder.sv
// tb/tb_orao_tap_recorder.sv - self-checking bench for orao_tap_recorder; honours ORAO_TAPREC_AUTOSTOP_EN
module tb_orao_tap_recorder;

    localparam int SD     = 4;
    localparam int DEPTH  = 16;
    localparam int IDLE_S = 10;

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic        ce_1m;
    logic        arm;
    logic        tape_in;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        recording;
    logic        done;
    logic        overflow;
    logic [23:0] byte_count;

    int   n_cmp  = 0;
    int   n_fail = 0;
    int   cc     = 0;
    bit   rnd_ready = 1'b0;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    int   chg_off[$];
    logic chg_lvl[$];

    orao_tap_recorder #(
        .SAMPLE_DIV   (SD),
        .FIFO_DEPTH   (DEPTH),
        .IDLE_SAMPLES (16'd10)
    ) dut (
        .clk_sys    (clk_sys),
        .reset_n    (reset_n),
        .ce_1m      (ce_1m),
        .arm        (arm),
        .tape_in    (tape_in),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .recording  (recording),
        .done       (done),
        .overflow   (overflow),
        .byte_count (byte_count)
    );

    always #5 clk_sys = ~clk_sys;

    // One ce_1m pulse every 8 system clocks.
    initial begin
        ce_1m = 1'b0;
        forever begin
            @(posedge clk_sys);
            #1;
            cc    = (cc + 1) % 8;
            ce_1m = (cc == 0);
        end
    end

    initial begin
        forever begin
            @(posedge clk_sys);
            #2;
            if (rnd_ready)
                out_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        forever begin
            @(negedge clk_sys);
            if (reset_n && out_valid && out_ready)
                got_q.push_back(out_data);
        end
    end

    // Advance n sample-clock microseconds; lands 3 clocks before the next ce_1m pulse.
    task automatic tick_us(input int n);
        repeat (n) begin
            @(posedge clk_sys);
            while (!ce_1m) @(posedge clk_sys);
        end
        repeat (5) @(posedge clk_sys);
        #1;
    endtask

    task automatic gen_changes(input logic first, input int max_off, input int max_gap, input bit avoid4);
        int   off;
        logic l;
        chg_off.delete();
        chg_lvl.delete();
        chg_off.push_back(0);
        chg_lvl.push_back(first);
        off = 0;
        l   = first;
        forever begin
            off += int'($urandom_range(1, max_gap));
            if (avoid4 && (off % SD) == 0)
                off++;
            if (off >= max_off)
                break;
            l = ~l;
            chg_off.push_back(off);
            chg_lvl.push_back(l);
        end
    endtask

    task automatic play(input int from_h, input int to_h, input int drop);
        for (int h = from_h; h < to_h; h++) begin
            foreach (chg_off[i])
                if (chg_off[i] == h)
                    tape_in = chg_lvl[i];
            if (h == drop)
                arm = 1'b0;
            tick_us(1);
        end
    endtask

    // Sample k is taken k*SD us after the first edge and reflects every change made at or before then.
    task automatic build_expect(input int drop, input bit autostop);
        int   last;
        int   t;
        logic l;
        exp_q.delete();
        last = chg_off[$];
        for (int k = 0; k < 10000; k++) begin
            t = SD * k;
            if (drop >= 0 && t >= drop)
                break;
            l = chg_lvl[0];
            foreach (chg_off[i])
                if (chg_off[i] <= t)
                    l = chg_lvl[i];
            exp_q.push_back(l ? 8'h40 : 8'h00);
            if (autostop && t > last && (k - last / SD) >= IDLE_S)
                break;
        end
    endtask

    function automatic int first_diff();
        int n;
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            if (got_q[i] !== exp_q[i])
                return i;
        if (got_q.size() != exp_q.size())
            return n;
        return -1;
    endfunction

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk_sys);
            if (done === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        tick_us(1);
    endtask

    task automatic test_reset;
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", out_valid); end
        n_cmp++; if (out_data !== 8'h00) begin n_fail++; $display("FAIL reset_data got %h want 00", out_data); end
        n_cmp++; if (recording !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL reset_flags got rec=%b done=%b want 0/0", recording, done); end
        n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow got %b want 0", overflow); end
        n_cmp++; if (byte_count !== 24'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", byte_count); end
    endtask

    task automatic test_basic_take;
        bit ok;
        int d;
        got_q.delete();
        out_ready = 1'b1;
        arm = 1'b1;
        tick_us(2);
        n_cmp++; if (recording !== 1'b0) begin n_fail++; $display("FAIL basic_armed_rec got %b want 0", recording); end
        chg_off = '{0, 20};
        chg_lvl = '{1'b1, 1'b0};
        build_expect(32, 1'b0);
        play(0, 3, -1);
        n_cmp++; if (recording !== 1'b1) begin n_fail++; $display("FAIL basic_rec got %b want 1", recording); end
        play(3, 33, 32);
        wait_done(ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL basic_done got timeout want done=1"); end
        n_cmp++; if (recording !== 1'b0) begin n_fail++; $display("FAIL basic_rec_end got %b want 0", recording); end
        d = first_diff();
        n_cmp++; if (d !== -1) begin n_fail++; $display("FAIL basic_stream at %0d got %0d bytes want %0d", d, got_q.size(), exp_q.size()); end
        n_cmp++; if (byte_count !== 24'(got_q.size())) begin n_fail++; $display("FAIL basic_count got %0d want %0d", byte_count, got_q.size()); end
        arm = 1'b0;
        tick_us(2);
        n_cmp++; if (done !== 1'b1) begin n_fail++; $display("FAIL basic_done_hold got %b want 1", done); end
    endtask

    task automatic test_random_take;
        bit ok;
        int d;
        int drop;
        for (int it = 0; it < 3; it++) begin
            got_q.delete();
            rnd_ready = 1'b1;
            arm = 1'b1;
            tick_us(2);
            n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL rand_rearm_done[%0d] got %b want 0", it, done); end
            gen_changes(~tape_in, 100, 30, 1'b0);
            drop = chg_off[$] + int'($urandom_range(1, 30));
            build_expect(drop, 1'b0);
            play(0, drop + 1, drop);
            wait_done(ok);
            n_cmp++; if (!ok) begin n_fail++; $display("FAIL rand_done[%0d] got timeout want done=1", it); end
            d = first_diff();
            n_cmp++; if (d !== -1) begin n_fail++; $display("FAIL rand_stream[%0d] at %0d got %0d bytes want %0d", it, d, got_q.size(), exp_q.size()); end
            n_cmp++; if (byte_count !== 24'(exp_q.size())) begin n_fail++; $display("FAIL rand_count[%0d] got %0d want %0d", it, byte_count, exp_q.size()); end
            rnd_ready = 1'b0;
            out_ready = 1'b1;
            tick_us(1);
        end
    endtask

    task automatic test_backpressure;
        bit ok;
        int d;
        got_q.delete();
        out_ready = 1'b0;
        arm = 1'b1;
        tick_us(2);
        gen_changes(~tape_in, 60, 20, 1'b0);
        build_expect(65, 1'b0);
        play(0, 61, -1);
        n_cmp++; if (byte_count !== 24'd16 || overflow !== 1'b0) begin n_fail++; $display("FAIL bp_full got cnt=%0d ovf=%b want 16/0", byte_count, overflow); end
        n_cmp++; if (out_valid !== 1'b1 || out_data !== exp_q[0]) begin n_fail++; $display("FAIL bp_head_hold got v=%b d=%h want 1/%h", out_valid, out_data, exp_q[0]); end
        play(61, 64, -1);
        repeat (2) @(posedge clk_sys);
        #1 out_ready = 1'b1;
        @(posedge clk_sys);
        #1 out_ready = 1'b0;
        n_cmp++; if (overflow !== 1'b0 || byte_count !== 24'd17) begin n_fail++; $display("FAIL bp_pop_push got ovf=%b cnt=%0d want 0/17", overflow, byte_count); end
        tick_us(4);
        n_cmp++; if (overflow !== 1'b1 || byte_count !== 24'd17) begin n_fail++; $display("FAIL bp_overflow got ovf=%b cnt=%0d want 1/17", overflow, byte_count); end
        n_cmp++; if (out_data !== exp_q[1]) begin n_fail++; $display("FAIL bp_head_next got %h want %h", out_data, exp_q[1]); end
        arm = 1'b0;
        out_ready = 1'b1;
        wait_done(ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL bp_done got timeout want done=1"); end
        d = first_diff();
        n_cmp++; if (d !== -1) begin n_fail++; $display("FAIL bp_stream at %0d got %0d bytes want %0d", d, got_q.size(), exp_q.size()); end
        n_cmp++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL bp_sticky got %b want 1", overflow); end
        arm = 1'b1;
        tick_us(2);
        n_cmp++; if (overflow !== 1'b0 || byte_count !== 24'd0 || done !== 1'b0) begin n_fail++; $display("FAIL bp_rearm got ovf=%b cnt=%0d done=%b want 0/0/0", overflow, byte_count, done); end
        arm = 1'b0;
        tick_us(2);
    endtask

    task automatic test_autostop;
        bit ok;
        int d;
        int last;
        got_q.delete();
        out_ready = 1'b1;
        arm = 1'b1;
        tick_us(2);
        gen_changes(~tape_in, 50, 30, 1'b1);
        last = chg_off[$];
`ifdef ORAO_TAPREC_AUTOSTOP_EN
        build_expect(-1, 1'b1);
        play(0, last + 1, -1);
        wait_done(ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL auto_done got timeout want done=1 with arm high"); end
        n_cmp++; if (recording !== 1'b0) begin n_fail++; $display("FAIL auto_rec got %b want 0", recording); end
        d = first_diff();
        n_cmp++; if (d !== -1) begin n_fail++; $display("FAIL auto_stream at %0d got %0d bytes want %0d", d, got_q.size(), exp_q.size()); end
`else
        build_expect(last + 60, 1'b0);
        play(0, last + 50, -1);
        n_cmp++; if (recording !== 1'b1 || done !== 1'b0) begin n_fail++; $display("FAIL noauto_running got rec=%b done=%b want 1/0", recording, done); end
        play(last + 50, last + 61, last + 60);
        wait_done(ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL noauto_done got timeout want done=1"); end
        d = first_diff();
        n_cmp++; if (d !== -1) begin n_fail++; $display("FAIL noauto_stream at %0d got %0d bytes want %0d", d, got_q.size(), exp_q.size()); end
`endif
        arm = 1'b0;
        tick_us(2);
    endtask

    task automatic test_armed_abort;
        got_q.delete();
        out_ready = 1'b1;
        arm = 1'b1;
        tick_us(5);
        arm = 1'b0;
        tick_us(2);
        n_cmp++; if (recording !== 1'b0 || done !== 1'b0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL abort_flags got rec=%b done=%b v=%b want 0/0/0", recording, done, out_valid); end
        tape_in = ~tape_in;
        tick_us(20);
        n_cmp++; if (got_q.size() !== 0 || recording !== 1'b0 || byte_count !== 24'd0) begin n_fail++; $display("FAIL abort_idle got bytes=%0d rec=%b cnt=%0d want 0/0/0", got_q.size(), recording, byte_count); end
    endtask

    task automatic test_reset_mid_record;
        got_q.delete();
        out_ready = 1'b0;
        arm = 1'b1;
        tick_us(2);
        gen_changes(~tape_in, 18, 8, 1'b0);
        play(0, 18, -1);
        n_cmp++; if (byte_count !== 24'd5 || out_valid !== 1'b1) begin n_fail++; $display("FAIL rst_pre got cnt=%0d v=%b want 5/1", byte_count, out_valid); end
        reset_n = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 1'b0 || byte_count !== 24'd0 || recording !== 1'b0) begin n_fail++; $display("FAIL rst_async got v=%b cnt=%0d rec=%b want 0/0/0", out_valid, byte_count, recording); end
        @(posedge clk_sys);
        #1 reset_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tape_in = ~tape_in;
            tick_us(6);
        end
        n_cmp++; if (got_q.size() !== 0 || recording !== 1'b0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_after got bytes=%0d rec=%b v=%b want 0/0/0", got_q.size(), recording, out_valid); end
        arm = 1'b0;
        tick_us(2);
    endtask

    initial begin
        reset_n   = 1'b0;
        arm       = 1'b0;
        tape_in   = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk_sys);
        #1 reset_n = 1'b1;
        tick_us(1);
        test_reset;
        test_basic_take;
        test_random_take;
        test_backpressure;
        test_autostop;
        test_armed_abort;
        test_reset_mid_record;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
